alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle multiply sequencer that drives a single ALU instance through radix-2 shift-add iterations to produce LEGv8 MUL, UMULH and SMULH results. It sits in the EX stage beside the main ALU path and is started by the pipeline control for multiply instructions. While it runs it asserts `busy` so the hazard unit can stall.

## Interface
- `W`, default `WORD` (64): operand and result width.
- `CW`, default $clog2(W) (6): iteration counter width.

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `op` input 2: 00 MUL (low W bits), 01 UMULH, 10 SMULH, 11 reserved.
- `a` input W: multiplicand, captured on accepted `start`.
- `b` input W: multiplier, captured on accepted `start`.
- `busy` output 1: high from cycle after accept until `done` cycle inclusive.
- `done` output 1: one-cycle pulse, `result` valid.
- `result` output W: product word; held until next accepted `start`.
- `zero` output 1: `result == 0`, registered with `result`.
- `err` output 1: pulses with `done` for op 11 (or op 10 without SMULH_EN).

## Operation
- States: IDLE, ITER, FIX1, FIX2, DONE.
- IDLE: `start`=1 -> capture `a`->mcand, `b`->lo, hi<=0, cnt<=0, latch op; go ITER. Illegal op -> go DONE directly, `result`=0, `err`=1.
- ITER (W cycles): ALU driven with ALUCtl ADD (0010), a=hi, b=lo[0] ? mcand : 0. Carry computed locally: c = (x[W-1]&y[W-1]) | ((x[W-1]|y[W-1]) & ~sum[W-1]) (ALU Co is not used). {hi,lo} <= {c,sum,lo} >> 1. cnt==W-1 -> MUL/UMULH go DONE, SMULH go FIX1.
- FIX1: ALU SUB (0110): hi <= hi - (mcand[W-1] ? b_orig : 0); b_orig kept in a separate register.
- FIX2: ALU SUB: hi <= hi - (b_orig[W-1] ? mcand : 0); go DONE.
- DONE: `result` <= lo (MUL) or hi (UMULH/SMULH); `done`=1; next state IDLE.
- ALU Overflow/Negative/Zero outputs ignored; all arithmetic modulo 2^W.
- `start` while busy: ignored, no queuing.

## Timing
- Reset (async, any state): state IDLE; `busy`=0, `done`=0, `err`=0, `result`=0, `zero`=1, internal registers 0.
- Reset mid-operation aborts with no `done`.
- Accept at edge 0 -> `busy` high from cycle 1; MUL/UMULH `done` at cycle W+1 (65); SMULH at W+3 (67); illegal op at cycle 1.
- `start` may be re-asserted in the cycle after `done` (IDLE); back-to-back issue rate W+2 cycles.
- `result`, `zero` update only in DONE; stable otherwise.

## Configuration
- `ALU_MUL_SMULH_EN` defined: FIX1/FIX2 states and b_orig register present; op 10 returns signed high word.
- Undefined: FIX states and b_orig removed; op 10 treated as illegal (`result`=0, `err`=1, `done` at cycle 1).

## Structure
- Shared package/common header: `WORD`, ALU control codes (ALU_ADD, ALU_SUB), op codes MULOP_MUL/MULOP_UMULH/MULOP_SMULH, state encodings.
- One sub-module: the existing `ALU`, instantiated once; sequencer owns its a/b/ALUCtl inputs. Carry logic and shift registers stay in this module.

## Test plan
- MUL a=3, b=5 -> `done` at cycle 65, `result`=15, `zero`=0, `err`=0.
- UMULH a=b=0xFFFF_FFFF_FFFF_FFFF -> `result`=0xFFFF_FFFF_FFFF_FFFE; MUL same -> 1.
- SMULH (macro on) a=-1, b=-1 -> `result`=0 at cycle 67; a=-2, b=3 -> 0xFFFF_FFFF_FFFF_FFFF.
- op=11 (and op=10 with macro off) -> `done`+`err` at cycle 1, `result`=0, `zero`=1.
- `start` pulsed with different operands at cycle 10 during MUL 7x9 -> ignored, `result`=63.
- `rst_n` low at cycle 30 of UMULH -> outputs reset immediately, no `done`; new MUL 2x2 after release -> 4.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared definitions for the multi-cycle multiply sequencer and its ALU:
// word width, LEGv8 ALU control codes, multiply op codes, sequencer states,
// and a helper that tells whether an op code is executable in this build.
// Configuration macro: ALU_MUL_SMULH_EN (enables SMULH; otherwise op 10 is
// treated as illegal).
// -----------------------------------------------------------------------------
package alu_mul_seq_pkg;

  localparam int WORD = 64;

  // LEGv8 ALU control encodings
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  // Multiply op codes as presented on the op port
  localparam logic [1:0] MULOP_MUL   = 2'b00;
  localparam logic [1:0] MULOP_UMULH = 2'b01;
  localparam logic [1:0] MULOP_SMULH = 2'b10;
  localparam logic [1:0] MULOP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ITER = 3'd1,
    S_FIX1 = 3'd2,
    S_FIX2 = 3'd3,
    S_DONE = 3'd4
  } mul_state_e;

  // True when the op code can be executed by this build of the sequencer.
  function automatic logic mul_op_legal(input logic [1:0] op);
`ifdef ALU_MUL_SMULH_EN
    return op != MULOP_RSVD;
`else
    return (op == MULOP_MUL) || (op == MULOP_UMULH);
`endif
  endfunction

endpackage

// File: rtl/alu_mul_seq_alu.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_alu
// The LEGv8 EX-stage ALU (combinational). The multiply sequencer owns its
// inputs while a multiply is in flight.
// Ports:
//   a, b      : W-bit operands
//   alu_ctl   : 4-bit LEGv8 ALU control (AND/OR/ADD/SUB/PASSB/NOR)
//   alu_out   : W-bit result
//   zero      : alu_out == 0
//   overflow  : signed overflow for ADD/SUB
//   negative  : alu_out[W-1]
//   co        : carry out of the adder (borrow-inverted for SUB)
// -----------------------------------------------------------------------------
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
#(
  parameter int W = WORD
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   alu_ctl,
  output logic [W-1:0] alu_out,
  output logic         zero,
  output logic         overflow,
  output logic         negative,
  output logic         co
);

  logic         sub;
  logic [W-1:0] b_eff;
  logic [W:0]   add_res;

  // Subtraction is a + ~b + 1 through the same adder.
  assign sub     = (alu_ctl == ALU_SUB);
  assign b_eff   = sub ? ~b : b;
  assign add_res = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    alu_out = '0;
    unique case (alu_ctl)
      ALU_AND:          alu_out = a & b;
      ALU_OR:           alu_out = a | b;
      ALU_ADD, ALU_SUB: alu_out = add_res[W-1:0];
      ALU_PASSB:        alu_out = b;
      ALU_NOR:          alu_out = ~(a | b);
      default:          alu_out = '0;
    endcase
  end

  assign zero     = (alu_out == '0);
  assign negative = alu_out[W-1];
  assign co       = add_res[W];
  assign overflow = ((alu_ctl == ALU_ADD) || sub) &&
                    (a[W-1] == b_eff[W-1]) && (alu_out[W-1] != a[W-1]);

endmodule

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle radix-2 shift-add multiply sequencer for LEGv8 MUL, UMULH and
// SMULH. It drives one ALU instance for W ADD iterations, then (SMULH only)
// two SUB correction steps that turn the unsigned high word into the signed
// one. busy stays high from the cycle after accept through the done cycle so
// the hazard unit can stall.
// Configuration macro: ALU_MUL_SMULH_EN. When undefined the correction states
// and the saved multiplier are absent and op 10 completes as illegal.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only while idle
//   op         : 00 MUL, 01 UMULH, 10 SMULH, 11 reserved
//   a, b       : multiplicand / multiplier, captured on accepted start
//   busy       : operation in flight (includes the done cycle)
//   done       : one-cycle pulse, result valid
//   result     : product word, held until the next completion
//   zero       : result == 0, registered with result
//   err        : pulses with done for an illegal op
// -----------------------------------------------------------------------------
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int W  = WORD,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         err
);

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  mul_state_e    state, state_d;
  logic [W-1:0]  mcand;
  logic [W-1:0]  hi, hi_d;
  logic [W-1:0]  lo, lo_d;
  logic [CW-1:0] cnt;
  logic [1:0]    op_r;
  logic          err_r;
`ifdef ALU_MUL_SMULH_EN
  logic [W-1:0]  b_orig;
`endif

  logic          accept;
  logic          op_ok;
  logic          load_res;
  logic [W-1:0]  res_d;

  // ALU hookup
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [3:0]    alu_ctl;
  logic          alu_zero, alu_ovf, alu_neg, alu_co;
  logic          alu_flags_unused;
  logic          carry;

  alu_mul_seq_alu #(.W(W)) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .alu_ctl  (alu_ctl),
    .alu_out  (alu_out),
    .zero     (alu_zero),
    .overflow (alu_ovf),
    .negative (alu_neg),
    .co       (alu_co)
  );

  // The multiply only consumes the ALU sum; its flags are not meaningful here.
  assign alu_flags_unused = ^{alu_zero, alu_ovf, alu_neg, alu_co};

  // ALU operand selection, kept apart from the next-state logic so the
  // sum can feed back into the shift registers without a comb-block loop.
  assign alu_a = hi;

  always_comb begin
    alu_ctl = ALU_ADD;
    alu_b   = '0;
    unique case (state)
      S_ITER: alu_b = lo[0] ? mcand : '0;
`ifdef ALU_MUL_SMULH_EN
      // Signed correction: subtract b when a is negative, a when b is negative.
      S_FIX1: begin
        alu_ctl = ALU_SUB;
        alu_b   = mcand[W-1] ? b_orig : '0;
      end
      S_FIX2: begin
        alu_ctl = ALU_SUB;
        alu_b   = b_orig[W-1] ? mcand : '0;
      end
`endif
      default: ;
    endcase
  end

  // Carry out of hi + addend recovered from the operand and sum MSBs, so the
  // ALU's own carry port is not needed.
  assign carry = (alu_a[W-1] & alu_b[W-1]) |
                 ((alu_a[W-1] | alu_b[W-1]) & ~alu_out[W-1]);

  assign op_ok = mul_op_legal(op);

  // Next state and datapath next values
  always_comb begin
    state_d  = state;
    hi_d     = hi;
    lo_d     = lo;
    accept   = 1'b0;
    load_res = 1'b0;
    res_d    = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_d  = op_ok ? S_ITER : S_DONE;
          // An illegal op completes immediately with a zero result.
          load_res = !op_ok;
        end
      end
      S_ITER: begin
        // {hi,lo} <= {carry,sum,lo} >> 1
        hi_d = {carry, alu_out[W-1:1]};
        lo_d = {alu_out[0], lo[W-1:1]};
        if (cnt == LAST_ITER) begin
`ifdef ALU_MUL_SMULH_EN
          if (op_r == MULOP_SMULH) begin
            state_d = S_FIX1;
          end else begin
            state_d  = S_DONE;
            load_res = 1'b1;
          end
`else
          state_d  = S_DONE;
          load_res = 1'b1;
`endif
        end
      end
`ifdef ALU_MUL_SMULH_EN
      S_FIX1: begin
        hi_d    = alu_out;
        state_d = S_FIX2;
      end
      S_FIX2: begin
        hi_d     = alu_out;
        state_d  = S_DONE;
        load_res = 1'b1;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The result register is loaded on the edge into DONE so it is valid
    // together with the done pulse.
    if (load_res && !accept) begin
      res_d = (op_r == MULOP_MUL) ? lo_d : hi_d;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      op_r   <= MULOP_MUL;
      err_r  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      if (accept) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        cnt   <= '0;
        op_r  <= op;
        err_r <= !op_ok;
      end else begin
        hi <= hi_d;
        lo <= lo_d;
        if (state == S_ITER) begin
          cnt <= cnt + CW'(1);
        end
      end
      if (load_res) begin
        result <= res_d;
        zero   <= (res_d == '0);
      end
    end
  end

`ifdef ALU_MUL_SMULH_EN
  // Original multiplier, needed by the signed correction after lo has been
  // shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_orig <= '0;
    end else if (accept) begin
      b_orig <= b;
    end
  end
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = done & err_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Self-checking bench for alu_mul_seq. Expected products come from full-width
// 2W-bit arithmetic; latencies and error behaviour from the op semantics.
// Honours ALU_MUL_SMULH_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy, done, zero, err;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_held;

  alu_mul_seq #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
    end
  endtask

  // Reference: result, err flag and done latency (cycles after accept).
  function automatic void ref_mul(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic e, output int lat);
    logic [2*W-1:0] pu;
    logic [2*W-1:0] ps;
    pu  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    ps  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    res = '0;
    e   = 1'b0;
    lat = W + 1;
    case (op)
      2'b00: res = pu[W-1:0];
      2'b01: res = pu[2*W-1:W];
`ifdef ALU_MUL_SMULH_EN
      2'b10: begin
        res = ps[2*W-1:W];
        lat = W + 3;
      end
`endif
      default: begin
        e   = 1'b1;
        lat = 1;
      end
    endcase
  endfunction

  // Issue one operation, optionally pulse start again at cycle poke_cyc,
  // wait (bounded) for done and check everything about the completion.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke_cyc);
    logic [W-1:0] er;
    logic         ee;
    int           lat;
    int           cyc;
    ref_mul(op, a, b, er, ee, lat);
    @(negedge clk);
    start = 1'b1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i  = ~op;
    a_i   = ~a;
    b_i   = ~b;
    cyc   = 1;
    check({tag, ".busy1"}, W'(busy), W'(1));
    if (lat > 1) check({tag, ".held"}, result, exp_held);
    while (!done && cyc < 200) begin
      if (cyc == poke_cyc) begin
        start = 1'b1;
        op_i  = MULOP_UMULH;
        a_i   = {$urandom, $urandom};
        b_i   = {$urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, W'(done), W'(1));
    check({tag, ".latency"}, W'(cyc), W'(lat));
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, W'(zero), W'(er == '0));
    check({tag, ".err"}, W'(err), W'(ee));
    check({tag, ".busy_done"}, W'(busy), W'(1));
    exp_held = er;
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, W'(done), W'(0));
    check({tag, ".idle"}, W'(busy), W'(0));
    check({tag, ".hold"}, result, er);
  endtask

  initial begin
    int seen;
    rst_n = 1'b1;
    start = 1'b0;
    op_i  = 2'b00;
    a_i   = '0;
    b_i   = '0;
    #2 rst_n = 1'b0;
    #3;
    check("reset.busy", W'(busy), W'(0));
    check("reset.done", W'(done), W'(0));
    check("reset.err", W'(err), W'(0));
    check("reset.result", result, '0);
    check("reset.zero", W'(zero), W'(1));
    exp_held = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("mul_3x5", MULOP_MUL, 64'd3, 64'd5, 0);
    run_op("umulh_ones", MULOP_UMULH, ONES, ONES, 0);
    run_op("mul_ones", MULOP_MUL, ONES, ONES, 0);
    run_op("smulh_m1m1", MULOP_SMULH, ONES, ONES, 0);
    run_op("smulh_m2x3", MULOP_SMULH, -64'sd2, 64'd3, 0);
    run_op("smulh_min", MULOP_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op("rsvd", MULOP_RSVD, 64'd7, 64'd9, 0);
    run_op("mul_zero", MULOP_MUL, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
    run_op("mul_7x9_poke", MULOP_MUL, 64'd7, 64'd9, 10);

    // Reset in the middle of a UMULH: immediate reset values, no done.
    @(negedge clk);
    start = 1'b1;
    op_i  = MULOP_UMULH;
    a_i   = ONES;
    b_i   = 64'd12345;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", W'(busy), W'(0));
    check("midrst.done", W'(done), W'(0));
    check("midrst.err", W'(err), W'(0));
    check("midrst.result", result, '0);
    check("midrst.zero", W'(zero), W'(1));
    exp_held = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("midrst.no_done", W'(seen), W'(0));
    run_op("mul_2x2", MULOP_MUL, 64'd2, 64'd2, 0);

    // Randomised operations against the reference
    for (int i = 0; i < 16; i++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), rop, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
